// File: rtl/motion_source_arbiter_if.sv
// Request/position bundle between the three motion sources and the sprite position arbiter.
interface motion_source_arbiter_if;
    logic [1:0] mode;
    logic       freeze;
    logic [3:0] req_btn;
    logic [3:0] req_acc;
    logic [3:0] req_js;
    logic [9:0] pos_c;
    logic [8:0] pos_r;
    logic [1:0] owner;
    logic       step_tick;
    logic       moving;

    modport master (
        output mode, freeze, req_btn, req_acc, req_js,
        input  pos_c, pos_r, owner, step_tick, moving
    );

    modport slave (
        input  mode, freeze, req_btn, req_acc, req_js,
        output pos_c, pos_r, owner, step_tick, moving
    );
endinterface

// File: rtl/motion_source_arbiter.sv
// Sprite position controller: paces moves with a step tick and arbitrates the position
// register between buttons, accelerometer and joystick, clamping to the visible area.
module motion_source_arbiter #(
    parameter int unsigned TICK_DIV   = 10000,
    parameter int unsigned HOLD_TICKS = 64,
    parameter int unsigned SPR_W      = 128,
    parameter int unsigned SPR_H      = 128,
    parameter int unsigned SCR_W      = 640,
    parameter int unsigned SCR_H      = 480,
    parameter int unsigned INIT_C     = 320,
    parameter int unsigned INIT_R     = 240
) (
    input  logic                    btn_clk,
    input  logic                    arst_n,
    motion_source_arbiter_if.slave  bus
);

    localparam int unsigned CNT_W   = $clog2(TICK_DIV);
    localparam int unsigned HOLD_W  = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam int unsigned COL_MAX = SCR_W - 1 - SPR_W;
    localparam int unsigned ROW_MAX = SCR_H - 1 - SPR_H;

    localparam logic [1:0] SRC_NONE = 2'b00;
    localparam logic [1:0] SRC_BTN  = 2'b01;
    localparam logic [1:0] SRC_ACC  = 2'b10;
    localparam logic [1:0] SRC_JS   = 2'b11;

    typedef enum logic {S_IDLE, S_OWN} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [1:0]          mode_q, mode_d;
    logic [1:0]          owner_q, owner_d;
    logic [9:0]          pos_c_q, pos_c_d;
    logic [8:0]          pos_r_q, pos_r_d;
    logic                step_tick_q, step_tick_d;
    logic                moving_q, moving_d;
    logic [3:0]          step_req;
    logic [3:0]          own_req;

    // Request vector of a given source code; SRC_NONE yields no request.
    function automatic logic [3:0] sel_req(input logic [1:0] src, input logic [3:0] b,
                                           input logic [3:0] a, input logic [3:0] j);
        logic [3:0] r;
        case (src)
            SRC_BTN: r = b;
            SRC_ACC: r = a;
            SRC_JS:  r = j;
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

    // Column step: bit1 = left, bit0 = right; opposing requests cancel, bounds saturate.
    function automatic logic [9:0] step_col(input logic [9:0] c, input logic [3:0] r);
        logic [9:0] n;
        n = c;
        if (r[1] && !r[0] && (c != 10'd0))
            n = c - 10'd1;
        else if (r[0] && !r[1] && (c < 10'(COL_MAX)))
            n = c + 10'd1;
        return n;
    endfunction

    // Row step: bit3 = up, bit2 = down.
    function automatic logic [8:0] step_row(input logic [8:0] rw, input logic [3:0] r);
        logic [8:0] n;
        n = rw;
        if (r[3] && !r[2] && (rw != 9'd0))
            n = rw - 9'd1;
        else if (r[2] && !r[3] && (rw < 9'(ROW_MAX)))
            n = rw + 9'd1;
        return n;
    endfunction

    always_comb begin
        cnt_d       = (cnt_q == CNT_W'(TICK_DIV - 1)) ? '0 : cnt_q + CNT_W'(1);
        step_tick_d = (cnt_q == CNT_W'(TICK_DIV - 1));
        mode_d      = bus.mode;
        state_d     = state_q;
        owner_d     = owner_q;
        hold_d      = hold_q;
        step_req    = 4'b0000;
        own_req     = sel_req(owner_q, bus.req_btn, bus.req_acc, bus.req_js);

        if (bus.mode != mode_q) begin
            // Mode switch wins over any tick; auto mode maps to owner none.
            state_d = S_IDLE;
            hold_d  = '0;
            owner_d = bus.mode;
        end else if (mode_q != SRC_NONE) begin
            state_d = S_IDLE;
            owner_d = mode_q;
            if (step_tick_q && !bus.freeze)
                step_req = sel_req(mode_q, bus.req_btn, bus.req_acc, bus.req_js);
        end else if (step_tick_q && !bus.freeze) begin
            case (state_q)
                S_IDLE: begin
                    // Fixed priority: buttons, then joystick, then accelerometer.
                    if (|bus.req_btn) begin
                        owner_d  = SRC_BTN;
                        step_req = bus.req_btn;
                    end else if (|bus.req_js) begin
                        owner_d  = SRC_JS;
                        step_req = bus.req_js;
                    end else if (|bus.req_acc) begin
                        owner_d  = SRC_ACC;
                        step_req = bus.req_acc;
                    end else begin
                        owner_d  = SRC_NONE;
                    end
                    if (owner_d != SRC_NONE) begin
                        state_d = S_OWN;
                        hold_d  = HOLD_W'(HOLD_TICKS - 1);
                    end
                end
                S_OWN: begin
                    if (|own_req) begin
                        step_req = own_req;
                        hold_d   = HOLD_W'(HOLD_TICKS - 1);
                    end else if (hold_q != '0) begin
                        hold_d   = hold_q - HOLD_W'(1);
                    end else begin
                        state_d  = S_IDLE;
                        owner_d  = SRC_NONE;
                    end
                end
            endcase
        end

        pos_c_d  = step_col(pos_c_q, step_req);
        pos_r_d  = step_row(pos_r_q, step_req);
        moving_d = (pos_c_d != pos_c_q) || (pos_r_d != pos_r_q);
    end

    always_ff @(posedge btn_clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            hold_q      <= '0;
            mode_q      <= SRC_NONE;
            owner_q     <= SRC_NONE;
            pos_c_q     <= 10'(INIT_C);
            pos_r_q     <= 9'(INIT_R);
            step_tick_q <= 1'b0;
            moving_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            mode_q      <= mode_d;
            owner_q     <= owner_d;
            pos_c_q     <= pos_c_d;
            pos_r_q     <= pos_r_d;
            step_tick_q <= step_tick_d;
            moving_q    <= moving_d;
        end
    end

    assign bus.pos_c     = pos_c_q;
    assign bus.pos_r     = pos_r_q;
    assign bus.owner     = owner_q;
    assign bus.step_tick = step_tick_q;
    assign bus.moving    = moving_q;

endmodule
